// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered per-LED colour store feeding led_driver.
// The writer fills the back bank and commits; banks swap only when a strand restarts at index 0.
module led_frame_buffer #(
    parameter  int NUM_LEDS      = 10,
    parameter  int COLOR_WIDTH   = 8,
    localparam int COUNTER_WIDTH = $clog2(NUM_LEDS)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [COUNTER_WIDTH-1:0] next_led_request,
    input  logic                     request_valid,
    output logic [COLOR_WIDTH-1:0]   red_out,
    output logic [COLOR_WIDTH-1:0]   green_out,
    output logic [COLOR_WIDTH-1:0]   blue_out,
    output logic                     color_ready,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [COUNTER_WIDTH-1:0] wr_addr,
    input  logic [COLOR_WIDTH-1:0]   wr_red,
    input  logic [COLOR_WIDTH-1:0]   wr_green,
    input  logic [COLOR_WIDTH-1:0]   wr_blue,
    input  logic                     wr_commit,
    output logic                     swap_done
);
    localparam int WORD_W = 3 * COLOR_WIDTH;
    localparam int DEPTH  = 2 * NUM_LEDS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(NUM_LEDS - 1);

    localparam logic [0:0] FILL      = 1'b0;
    localparam logic [0:0] WAIT_SWAP = 1'b1;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [0:0]        state;
    logic              front;
    logic              loaded;
    logic              pending;
    logic              swap_now;
    logic              rd_bank;
    logic              rd_in_range;
    logic              rd_show;
    logic              wr_fire;
    logic [WORD_W-1:0] rd_word;

    function automatic logic [ADDR_W-1:0] ram_addr(input logic bank,
                                                   input logic [COUNTER_WIDTH-1:0] idx);
        ram_addr = bank ? (ADDR_W'(NUM_LEDS) + ADDR_W'(idx)) : ADDR_W'(idx);
    endfunction

    assign pending  = (state == WAIT_SWAP);
    assign wr_ready = ~pending;
    assign wr_fire  = wr_valid & wr_ready & (wr_addr <= LAST_IDX);

    // The index-0 read that triggers a swap must already see the new front bank.
    assign swap_now    = pending & request_valid & (next_led_request == '0);
    assign rd_bank     = swap_now ? ~front : front;
    assign rd_in_range = (next_led_request <= LAST_IDX);
    assign rd_show     = rd_in_range & (loaded | swap_now);
    assign rd_word     = mem[ram_addr(rd_bank, rd_in_range ? next_led_request : '0)];

    always_ff @(posedge clk_in) begin
        if (wr_fire) begin
            mem[ram_addr(~front, wr_addr)] <= {wr_red, wr_green, wr_blue};
        end
    end

    // Bank control: commit freezes the back bank until the next strand start.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= FILL;
            front     <= 1'b0;
            loaded    <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= swap_now;
            if (swap_now) begin
                state  <= FILL;
                front  <= ~front;
                loaded <= 1'b1;
            end else if (wr_commit && !pending) begin
                state <= WAIT_SWAP;
            end
        end
    end

    // Read stage: one registered result per live request, held otherwise.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            red_out     <= '0;
            green_out   <= '0;
            blue_out    <= '0;
            color_ready <= 1'b0;
        end else begin
            color_ready <= request_valid;
            if (request_valid) begin
                if (rd_show) begin
                    {red_out, green_out, blue_out} <= rd_word;
                end else begin
                    {red_out, green_out, blue_out} <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_led_frame_buffer.sv
// Self-checking bench for led_frame_buffer: vector table, hand sequences and a
// randomized run, all compared against a frame-level model of the two banks.
module tb_led_frame_buffer;
    localparam int NUM_LEDS = 10;

    logic        clk_in;
    logic        rst_in;
    logic [3:0]  next_led_request;
    logic        request_valid;
    logic [7:0]  red_out, green_out, blue_out;
    logic        color_ready;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_red, wr_green, wr_blue;
    logic        wr_commit;
    logic        swap_done;

    led_frame_buffer #(.NUM_LEDS(NUM_LEDS), .COLOR_WIDTH(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .next_led_request(next_led_request), .request_valid(request_valid),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .color_ready(color_ready),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_red(wr_red), .wr_green(wr_green), .wr_blue(wr_blue),
        .wr_commit(wr_commit), .swap_done(swap_done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the two physical frames, which one is shown, and the commit/loaded flags.
    logic [23:0] m_mem [2][NUM_LEDS];
    bit          m_front, m_pending, m_loaded;
    bit          m_ready, m_swap;
    logic [23:0] m_color;

    typedef struct {
        bit          wv;
        logic [3:0]  wa;
        logic [23:0] wd;
        bit          cm;
        bit          rv;
        logic [3:0]  ri;
        bit          e_rdy;
        logic [23:0] e_col;
        bit          e_swp;
        bit          e_wrr;
    } vec_t;

    vec_t tbl [32];

    function automatic logic [23:0] col(input int i);
        return {8'(i), 8'(2 * i), 8'(3 * i)};
    endfunction

    function automatic vec_t mk(input bit wv, input logic [3:0] wa, input logic [23:0] wd,
                                input bit cm, input bit rv, input logic [3:0] ri,
                                input bit er, input logic [23:0] ec, input bit es, input bit ew);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.cm = cm; v.rv = rv; v.ri = ri;
        v.e_rdy = er; v.e_col = ec; v.e_swp = es; v.e_wrr = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] dut_color();
        return {red_out, green_out, blue_out};
    endfunction

    task automatic drive(input bit wv, input logic [3:0] wa, input logic [23:0] wd,
                         input bit cm, input bit rv, input logic [3:0] ri);
        wr_valid = wv; wr_addr = wa;
        wr_red = wd[23:16]; wr_green = wd[15:8]; wr_blue = wd[7:0];
        wr_commit = cm; request_valid = rv; next_led_request = ri;
    endtask

    task automatic model_reset();
        m_front = 1'b0; m_pending = 1'b0; m_loaded = 1'b0;
        m_ready = 1'b0; m_swap = 1'b0; m_color = '0;
    endtask

    // One clock: update the model from the sampled inputs, then compare.
    task automatic cycle();
        bit accepting;
        bit swap;
        int ri;
        int wa;
        @(posedge clk_in);
        ri = int'(next_led_request);
        wa = int'(wr_addr);
        accepting = !m_pending;
        swap = m_pending && request_valid && (ri == 0);
        if (wr_valid && accepting && wa < NUM_LEDS)
            m_mem[!m_front][wa] = {wr_red, wr_green, wr_blue};
        if (wr_commit && accepting) m_pending = 1'b1;
        if (swap) begin
            m_front = !m_front;
            m_pending = 1'b0;
            m_loaded = 1'b1;
        end
        m_swap = swap;
        m_ready = request_valid;
        if (request_valid)
            m_color = (m_loaded && ri < NUM_LEDS) ? m_mem[m_front][ri] : 24'h0;
        #1;
        chk("model_color_ready", 32'(color_ready), 32'(m_ready));
        chk("model_color", 32'(dut_color()), 32'(m_color));
        chk("model_swap_done", 32'(swap_done), 32'(m_swap));
        chk("model_wr_ready", 32'(wr_ready), 32'(!m_pending));
    endtask

    task automatic step(input bit wv, input logic [3:0] wa, input logic [23:0] wd,
                        input bit cm, input bit rv, input logic [3:0] ri);
        drive(wv, wa, wd, cm, rv, ri);
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int swaps;
        int strand;
        bit wv, cm, rv;
        logic [3:0] ri;

        k = 0;
        for (int i = 0; i < 10; i++) begin
            tbl[k] = mk(1'b0, 4'd0, 24'h0, 1'b0, 1'b1, 4'(i), 1'b1, 24'h0, 1'b0, 1'b1); k++;
        end
        for (int i = 0; i < 10; i++) begin
            tbl[k] = mk(1'b1, 4'(i), col(i), 1'b0, 1'b0, 4'd0, 1'b0, 24'h0, 1'b0, 1'b1); k++;
        end
        tbl[k] = mk(1'b0, 4'd0, 24'h0, 1'b1, 1'b0, 4'd0, 1'b0, 24'h0, 1'b0, 1'b0); k++;
        tbl[k] = mk(1'b0, 4'd0, 24'h0, 1'b0, 1'b0, 4'd0, 1'b0, 24'h0, 1'b0, 1'b0); k++;
        tbl[k] = mk(1'b0, 4'd0, 24'h0, 1'b0, 1'b1, 4'd0, 1'b1, col(0), 1'b1, 1'b1); k++;
        for (int i = 1; i < 10; i++) begin
            tbl[k] = mk(1'b0, 4'd0, 24'h0, 1'b0, 1'b1, 4'(i), 1'b1, col(i), 1'b0, 1'b1); k++;
        end

        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NUM_LEDS; i++) m_mem[b][i] = '0;
        model_reset();
        drive(1'b0, 4'd0, 24'h0, 1'b0, 1'b0, 4'd0);
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_color", 32'(dut_color()), 32'h0);
        chk("reset_color_ready", 32'(color_ready), 32'h0);
        chk("reset_swap_done", 32'(swap_done), 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("reset_wr_ready", 32'(wr_ready), 32'h1);

        // Reset gating followed by the basic frame
        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].cm, tbl[i].rv, tbl[i].ri);
            cycle();
            chk($sformatf("tbl%0d_color_ready", i), 32'(color_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_color", i), 32'(dut_color()), 32'(tbl[i].e_col));
            chk($sformatf("tbl%0d_swap_done", i), 32'(swap_done), 32'(tbl[i].e_swp));
            chk($sformatf("tbl%0d_wr_ready", i), 32'(wr_ready), 32'(tbl[i].e_wrr));
        end

        // Tear-free swap: commit frame B while the strand is at index 4
        for (int i = 0; i < 10; i++) step(1'b1, 4'(i), 24'hFFFFFF, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'd0, 24'h0, (i == 4), 1'b1, 4'(i));
            chk($sformatf("tear_idx%0d", i), 32'(dut_color()), 32'(col(i)));
        end
        step(1'b0, 4'd0, 24'h0, 1'b0, 1'b1, 4'd0);
        chk("tear_newframe_idx0", 32'(dut_color()), 32'hFFFFFF);
        chk("tear_swap_done", 32'(swap_done), 32'h1);
        step(1'b0, 4'd0, 24'h0, 1'b0, 1'b1, 4'd1);
        chk("tear_newframe_idx1", 32'(dut_color()), 32'hFFFFFF);

        // Edge handshakes
        step(1'b1, 4'd12, 24'h123456, 1'b0, 1'b0, 4'd0);
        chk("oor_write_accepted", 32'(wr_ready), 32'h1);
        step(1'b0, 4'd0, 24'h0, 1'b0, 1'b1, 4'd12);
        chk("oor_read_ready", 32'(color_ready), 32'h1);
        chk("oor_read_zero", 32'(dut_color()), 32'h0);
        step(1'b1, 4'd3, 24'hABCDEF, 1'b1, 1'b0, 4'd0);
        chk("commit_wr_ready_low", 32'(wr_ready), 32'h0);
        step(1'b0, 4'd0, 24'h0, 1'b1, 1'b1, 4'd5);
        chk("second_commit_no_swap", 32'(swap_done), 32'h0);
        chk("wait_swap_old_frame", 32'(dut_color()), 32'hFFFFFF);
        swaps = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'd0, 24'h0, 1'b0, 1'b1, 4'd0);
            if (swap_done) swaps++;
        end
        chk("held_idx0_single_swap", 32'(swaps), 32'd1);
        for (int i = 1; i < 10; i++) begin
            step(1'b0, 4'd0, 24'h0, 1'b0, 1'b1, 4'(i));
            chk($sformatf("edge_idx%0d", i), 32'(dut_color()), 32'((i == 3) ? 24'hABCDEF : col(i)));
        end

        // Reset mid-flight with a commit pending
        step(1'b1, 4'd0, 24'h111111, 1'b1, 1'b0, 4'd0);
        step(1'b0, 4'd0, 24'h0, 1'b0, 1'b1, 4'd3);
        chk("pre_reset_color", 32'(dut_color()), 32'hABCDEF);
        #2;
        rst_in = 1'b0;
        #1;
        model_reset();
        chk("async_reset_color", 32'(dut_color()), 32'h0);
        chk("async_reset_ready", 32'(color_ready), 32'h0);
        chk("async_reset_pending_clear", 32'(wr_ready), 32'h1);
        chk("async_reset_swap_done", 32'(swap_done), 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        swaps = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0, 24'h0, 1'b0, 1'b1, 4'd0);
            if (swap_done) swaps++;
        end
        chk("post_reset_no_swap", 32'(swaps), 32'd0);
        chk("post_reset_zero", 32'(dut_color()), 32'h0);
        for (int i = 0; i < 10; i++) step(1'b1, 4'(i), col(i) ^ 24'h5A5A5A, 1'b0, 1'b0, 4'd0);
        step(1'b0, 4'd0, 24'h0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'd0, 24'h0, 1'b0, 1'b1, 4'(i));
            chk($sformatf("recover_idx%0d", i), 32'(dut_color()), 32'(col(i) ^ 24'h5A5A5A));
        end

        // Randomized traffic against the model
        strand = 0;
        for (int n = 0; n < 3000; n++) begin
            wv = 1'($urandom_range(0, 1));
            cm = ($urandom_range(0, 15) == 0);
            rv = ($urandom_range(0, 3) != 0);
            ri = 4'd0;
            if (rv) begin
                if ($urandom_range(0, 7) == 0) begin
                    ri = 4'($urandom_range(0, 12));
                end else begin
                    ri = 4'(strand);
                    strand = (strand + 1) % NUM_LEDS;
                end
            end
            step(wv, 4'($urandom_range(0, 11)), 24'($urandom), cm, rv, ri);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
